// File: rtl/lcd_frame_buffer.sv
// lcd_frame_buffer: double-buffered LCD frame store with a hardware clear engine.
// Ports: CLK, RST (sync, active-high); Write_En_Sig/Write_Addr_Sig/Write_Data
//   write the back bank; Read_En_Sig/Read_Addr_Sig -> Read_Data/Read_Valid
//   (1-cycle latency) from the front bank; Swap_Req_Sig exchanges banks;
//   Clear_Req_Sig fills the back bank with FILL_VALUE; Busy while clearing;
//   Front_Bank is the bank currently scanned by the reader.
module lcd_frame_buffer #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 10,
    parameter int unsigned       DUAL_BANK  = 1,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Write_En_Sig,
    input  logic [ADDR_W-1:0] Write_Addr_Sig,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Read_En_Sig,
    input  logic [ADDR_W-1:0] Read_Addr_Sig,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Read_Valid,
    input  logic              Swap_Req_Sig,
    input  logic              Clear_Req_Sig,
    output logic              Busy,
    output logic              Front_Bank
);

    localparam int unsigned IDX_W = (DUAL_BANK != 0) ? ADDR_W + 1 : ADDR_W;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              pend_q;
    logic              pend_d;
    logic              front_q;
    logic              front_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    // Bank bit is the MSB of the flat index; single-bank mode drops it.
    generate
        if (DUAL_BANK != 0) begin : g_dual
            assign wr_idx = {~front_q, mem_wa};
            assign rd_idx = {front_q, Read_Addr_Sig};
        end else begin : g_single
            assign wr_idx = mem_wa;
            assign rd_idx = Read_Addr_Sig;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            front_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            front_q <= front_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        front_d = front_q;
        mem_we  = 1'b0;
        mem_wa  = Write_Addr_Sig;
        mem_wd  = Write_Data;
        unique case (state_q)
            IDLE: begin
                mem_we = Write_En_Sig;
                if (Clear_Req_Sig) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    // A swap alongside the clear waits for the clear to end.
                    pend_d  = Swap_Req_Sig;
                end else if (Swap_Req_Sig) begin
                    front_d = ~front_q;
                end
            end
            CLEAR: begin
                // Clear engine owns the write port; user writes are dropped.
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = FILL_VALUE;
                cnt_d  = cnt_q + 1'b1;
                if (Swap_Req_Sig) begin
                    pend_d = 1'b1;
                end
                // Compare-terminated: the final write ends the pass.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    if (pend_q || Swap_Req_Sig) begin
                        front_d = ~front_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (DUAL_BANK == 0) begin
            front_d = 1'b0;
            pend_d  = 1'b0;
        end
    end

    // Memory has no reset; writes are held off while RST is asserted.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[wr_idx] <= mem_wd;
        end
    end

    // Non-blocking read of the old word gives read-before-write on collision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Read_Data  <= '0;
            Read_Valid <= 1'b0;
        end else begin
            Read_Valid <= Read_En_Sig;
            if (Read_En_Sig) begin
                Read_Data <= mem[rd_idx];
            end
        end
    end

    assign Busy       = (state_q == CLEAR);
    assign Front_Bank = front_q;

endmodule

// File: doc/lcd_frame_buffer.md
Name: lcd_frame_buffer

Overview:
Parametrised, double-buffered frame store between the LCD pixel-generation logic (writer) and the LCD serialiser (reader). The writer fills a back bank while the reader scans a front bank. A swap request exchanges the banks. A hardware clear engine fills the back bank with a constant. Reads and writes proceed in the same cycle with no mutual blocking.

Parameters:
DATA_W, 8, width of one memory word (bits).
ADDR_W, 10, address width; each bank holds 2^ADDR_W words.
DUAL_BANK, 1, 1 = two banks (ping-pong); 0 = single bank, swap requests ignored.
FILL_VALUE, 0, word written by the clear engine (DATA_W bits).

Ports:
CLK  in  1  system clock, all logic on rising edge.
RST  in  1  synchronous, active-high reset.
Write_En_Sig  in  1  write strobe, one word per cycle.
Write_Addr_Sig  in  ADDR_W  write address within the back bank.
Write_Data  in  DATA_W  write data.
Read_En_Sig  in  1  read strobe.
Read_Addr_Sig  in  ADDR_W  read address within the front bank.
Read_Data  out  DATA_W  registered read data.
Read_Valid  out  1  high for one cycle when Read_Data has been updated.
Swap_Req_Sig  in  1  single-cycle request to exchange the front and back banks.
Clear_Req_Sig  in  1  single-cycle request to fill the back bank with FILL_VALUE.
Busy  out  1  clear engine active.
Front_Bank  out  1  index of the bank currently being read (0 or 1).

Behaviour:
- Interface: one clock, CLK. Reset is RST, synchronous and active-high.
- Reset values: Read_Data=0, Read_Valid=0, Busy=0, Front_Bank=0, state=IDLE, swap-pending=0, clear counter=0. Memory contents are not reset.
- Reset mid-clear aborts the clear; the bank is left partially filled; any pending swap is discarded.
- Bank select:
  - Writes target bank ~Front_Bank; reads target bank Front_Bank.
  - Front_Bank is the value sampled at the same edge as the access.
  - With DUAL_BANK=0 both ports address bank 0 and Front_Bank is held at 0.
- Read path: latency 1.
  - Read_En_Sig sampled high at edge N → Read_Data holds the addressed word after edge N, and Read_Valid=1 for the cycle after edge N.
  - With no read, Read_Data holds its previous value and Read_Valid=0.
- Write path: Write_En_Sig high at an edge writes Write_Data, unless Busy=1; writes while Busy are silently dropped.
- Read/write collision: only possible when DUAL_BANK=0. A read of the address written on the same edge returns the old word (read-before-write).
- State machine, states IDLE and CLEAR:
  - IDLE→CLEAR on Clear_Req_Sig=1. The counter loads 0 and Busy=1 from the next cycle.
  - In CLEAR, each edge writes FILL_VALUE to back-bank address = counter, then increments the counter.
  - The edge that writes address 2^ADDR_W-1 returns the state to IDLE. Busy is therefore high for exactly 2^ADDR_W cycles.
  - Clear_Req_Sig while Busy=1 is ignored. Reads continue normally during CLEAR.
- Swap:
  - In IDLE with no simultaneous clear request, Swap_Req_Sig=1 toggles Front_Bank on that edge.
  - Swap_Req_Sig while Busy=1, or on the same edge as an accepted Clear_Req_Sig, sets swap-pending. The pending swap toggles Front_Bank on the final clear-write edge and clears swap-pending. The freshly cleared bank is therefore the front bank when Busy falls.
  - Further swap requests while a swap is pending merge into the single pending swap.
  - A write on the same edge as a swap goes to the pre-swap back bank.
- Arithmetic: the clear counter is ADDR_W+1 bits or compare-terminated; it must not wrap into a second pass. All addresses are used unsigned, with no range checking (the full 2^ADDR_W space is valid).

Test Plan:
1. Reset then idle, DUAL_BANK=1, ADDR_W=4 → Read_Data=0, Read_Valid=0, Busy=0, Front_Bank=0; assert RST mid-clear later → Busy=0 on the next cycle.
2. Write 0xA5 to addr 3 (back bank 1), swap, read addr 3 → Read_Data=0xA5 one cycle after the read strobe, with Read_Valid high for exactly that cycle.
3. Simultaneous write of addr 7 (back) and read of addr 7 (front) on every cycle for 16 cycles → no stalls; read data comes from the front bank only.
4. Clear_Req with FILL_VALUE=0x3C → Busy high for exactly 16 cycles; Write_En during Busy is dropped; after a swap, all 16 words read 0x3C.
5. Swap_Req issued while Busy → Front_Bank toggles on the final clear edge, not earlier; a second Swap_Req while pending produces only one toggle.
6. DUAL_BANK=0: write 0x11 then, on the next edge, write 0x22 and read the same address → read returns 0x11; the following read returns 0x22; Swap_Req leaves Front_Bank=0.
